vdp_vram_arbiter: RTL and testbench
===================================

VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, the VRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the VRAM word width.
REQ-003 SHALL have parameter HOST_SLOT_INTERVAL, default 8: during active display the host gets one guaranteed slot per this many cycles.
REQ-004 SHALL have ports clk in 1, the clock, and reset in 1; reset is synchronous and active-high.
REQ-005 SHALL have ports hold_raster in 1 (freeze), active_display in 1 and frame_ended in 1, all from the raster timing block.
REQ-006 SHALL have ports bg_req in 1, bg_addr in ADDR_WIDTH and bg_grant out 1, for the background fetch requester.
REQ-007 SHALL have ports spr_req in 1, spr_addr in ADDR_WIDTH and spr_grant out 1, for the sprite fetch requester.
REQ-008 SHALL have host ports host_valid in 1, host_ready out 1, host_we in 1, host_addr in ADDR_WIDTH and host_wdata in DATA_WIDTH.
REQ-009 SHALL have VRAM ports vram_addr out ADDR_WIDTH, vram_we out 1, vram_wdata out DATA_WIDTH and vram_rdata in DATA_WIDTH; VRAM read latency is 1 cycle.
REQ-010 SHALL have return ports rdata out DATA_WIDTH, rdata_valid out 1 and rdata_owner out 2, with owner codes BG=0, SPR=1, HOST=2.
REQ-011 SHALL have port host_starve_cnt out 16, counting cycles in which host_valid was high and host_ready low, saturating.

Function
REQ-012 SHALL grant at most one requester per cycle; grants and host_ready are combinational from the current-cycle requests and state.
REQ-013 SHALL, when active_display=1, use priority bg > spr > host, except in a host slot.
REQ-014 SHALL define a host slot as a cycle with slot_cnt == HOST_SLOT_INTERVAL-1 and host_valid=1; in a host slot priority is host > bg > spr.
REQ-015 SHALL, when active_display=0 (blanking), use priority host > spr > bg.
REQ-016 SHALL advance slot_cnt by 1 each non-held cycle while active_display=1, wrapping from HOST_SLOT_INTERVAL-1 to 0.
REQ-017 SHALL clear slot_cnt to 0 while active_display=0, and on frame_ended=1.
REQ-018 SHALL treat a host transfer as complete on host_valid && host_ready; host_ready equals the host grant.
REQ-019 SHALL NOT let host_addr, host_we or host_wdata change the granted command after acceptance.
REQ-020 SHALL register the granted command onto vram_addr/vram_we/vram_wdata at the clock edge ending grant cycle N, so the command is valid in cycle N+1.
REQ-021 SHALL deassert vram_we in any cycle following a cycle with no host write grant; bg and spr are always reads.
REQ-022 SHALL present vram_rdata on rdata with rdata_valid=1 and the owner tag in cycle N+2 for reads; host writes produce no rdata_valid.
REQ-023 SHALL use a 2-stage owner/valid pipeline, giving back-to-back grants full throughput of one read per cycle.
REQ-024 SHALL, while hold_raster=1: drive all grants and host_ready to 0, freeze slot_cnt, and issue no new commands, with vram_we=0; in-flight reads still complete at N+2.
REQ-025 SHALL, when requests arrive simultaneously with a slot wrap, evaluate the host slot using the pre-increment slot_cnt.
REQ-026 SHALL, when the host slot occurs with host_valid=0, fall back to the normal active priority; the slot is not carried over.
REQ-027 SHALL saturate host_starve_cnt at 16'hFFFF and clear it on frame_ended.

Reset
REQ-028 SHALL, on reset, set slot_cnt=0, vram_addr=0, vram_we=0, vram_wdata=0, rdata_valid=0, rdata_owner=0, rdata=0 and host_starve_cnt=0.
REQ-029 SHALL drive all grants and host_ready to 0 while reset=1.
REQ-030 SHALL discard reads in flight when reset occurs mid-operation, with no rdata_valid after reset.

Structure
REQ-031 SHALL place the owner codes (BG/SPR/HOST) and the owner tag width in the shared vdp package.
REQ-032 SHALL implement the 2-stage read-return pipeline as the sub-module vdp_vram_return_pipe; the arbitration logic stays in the top module.

Verification
REQ-033 SHALL verify: with active_display=1 and bg_req, spr_req and host_valid held high continuously, host_ready is 1 in exactly 1 of every 8 cycles, bg_grant in the rest, and spr_grant never.
REQ-034 SHALL verify: with active_display=0, all three requesting, and host_we=1, host_addr=0x0123, host_wdata=0xBEEF, the next cycle shows vram_we=1, vram_addr=0x0123, vram_wdata=0xBEEF.
REQ-035 SHALL verify: a bg read of addr 0x0040 granted in cycle N yields rdata_valid=1, rdata_owner=0 and rdata = the VRAM model value in cycle N+2.
REQ-036 SHALL verify: hold_raster=1 for 5 cycles mid-line gives no grants, slot_cnt unchanged and host_starve_cnt incremented by 5 with host_valid=1; the prior read still returns.
REQ-037 SHALL verify: reset asserted one cycle after a spr read grant gives no rdata_valid afterwards, and all outputs at their reset values.
REQ-038 SHALL verify: frame_ended=1 clears slot_cnt and host_starve_cnt; a counter preloaded near 0xFFFF saturates at 0xFFFF.

Source files
------------

// File: rtl/vdp_vram_arbiter_pkg.sv
// Shared VDP definitions: VRAM requester owner codes and return-tag layout.
package vdp_vram_arbiter_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [OWNER_W-1:0] {
        OWN_BG   = 2'd0,
        OWN_SPR  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } ret_tag_t;

endpackage

// File: rtl/vdp_vram_arbiter_if.sv
// VRAM arbiter bus: fetch requesters, host port, VRAM command/data and read return.
interface vdp_vram_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) ();
    import vdp_vram_arbiter_pkg::*;

    logic                  bg_req;
    logic [ADDR_WIDTH-1:0] bg_addr;
    logic                  bg_grant;
    logic                  spr_req;
    logic [ADDR_WIDTH-1:0] spr_addr;
    logic                  spr_grant;
    logic                  host_valid;
    logic                  host_ready;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic [15:0]           host_starve_cnt;
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic                  vram_we;
    logic [DATA_WIDTH-1:0] vram_wdata;
    logic [DATA_WIDTH-1:0] vram_rdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic [OWNER_W-1:0]    rdata_owner;

    modport slave (
        input  bg_req, bg_addr, spr_req, spr_addr,
        input  host_valid, host_we, host_addr, host_wdata,
        input  vram_rdata,
        output bg_grant, spr_grant, host_ready, host_starve_cnt,
        output vram_addr, vram_we, vram_wdata,
        output rdata, rdata_valid, rdata_owner
    );

    modport master (
        output bg_req, bg_addr, spr_req, spr_addr,
        output host_valid, host_we, host_addr, host_wdata,
        output vram_rdata,
        input  bg_grant, spr_grant, host_ready, host_starve_cnt,
        input  vram_addr, vram_we, vram_wdata,
        input  rdata, rdata_valid, rdata_owner
    );

endinterface

// File: rtl/vdp_vram_return_pipe.sv
// Two-stage valid/owner pipeline aligning read tags with 1-cycle-latency VRAM data.
module vdp_vram_return_pipe
    import vdp_vram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_vld,
    input  owner_e                iss_owner,
    input  logic [DATA_WIDTH-1:0] vram_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic [OWNER_W-1:0]    rdata_owner
);
    localparam int STAGES = 2;

    logic [STAGES:1]               vld_pipe;
    logic [STAGES:1][OWNER_W-1:0]  own_pipe;

    // Stage 1 covers the command cycle, stage 2 the cycle VRAM drives data.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], iss_vld};
            own_pipe <= {own_pipe[1], iss_owner};
        end
    end

    assign rdata_valid = vld_pipe[STAGES];
    assign rdata_owner = own_pipe[STAGES];
    assign rdata       = vld_pipe[STAGES] ? vram_rdata : '0;

endmodule

// File: rtl/vdp_vram_arbiter.sv
// VRAM arbiter: bg/sprite/host priority with a guaranteed host slot during active display.
module vdp_vram_arbiter
    import vdp_vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH         = 15,
    parameter int DATA_WIDTH         = 16,
    parameter int HOST_SLOT_INTERVAL = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           hold_raster,
    input  logic           active_display,
    input  logic           frame_ended,
    vdp_vram_arbiter_if.slave bus
);
    localparam int SLOT_W = (HOST_SLOT_INTERVAL > 1) ? $clog2(HOST_SLOT_INTERVAL) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(HOST_SLOT_INTERVAL - 1);

    logic [SLOT_W-1:0]     slot_cnt;
    logic                  host_slot;
    logic                  bg_gnt, spr_gnt, host_gnt;
    logic                  iss_vld;
    owner_e                iss_owner;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_we;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [15:0]           starve_cnt;
    logic [DATA_WIDTH-1:0] ret_rdata;
    logic                  ret_valid;
    logic [OWNER_W-1:0]    ret_owner;

    // Slot is judged on the pre-increment count; an unused slot is simply lost.
    assign host_slot = active_display && bus.host_valid && (slot_cnt == SLOT_LAST);

    always_comb begin
        bg_gnt   = 1'b0;
        spr_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!reset && !hold_raster) begin
            if (!active_display) begin
                if (bus.host_valid)   host_gnt = 1'b1;
                else if (bus.spr_req) spr_gnt  = 1'b1;
                else if (bus.bg_req)  bg_gnt   = 1'b1;
            end else if (host_slot) begin
                host_gnt = 1'b1;
            end else begin
                if (bus.bg_req)          bg_gnt   = 1'b1;
                else if (bus.spr_req)    spr_gnt  = 1'b1;
                else if (bus.host_valid) host_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        iss_owner = OWN_BG;
        if (host_gnt)     iss_owner = OWN_HOST;
        else if (spr_gnt) iss_owner = OWN_SPR;
    end
    assign iss_vld = bg_gnt | spr_gnt | (host_gnt & ~bus.host_we);

    always_ff @(posedge clk) begin
        if (reset || frame_ended || !active_display) begin
            slot_cnt <= '0;
        end else if (!hold_raster) begin
            slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        end
    end

    // Host fields are sampled only on the grant edge, so later changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_addr  <= '0;
            cmd_we    <= 1'b0;
            cmd_wdata <= '0;
        end else begin
            cmd_we <= host_gnt & bus.host_we;
            if (host_gnt) begin
                cmd_addr <= bus.host_addr;
                if (bus.host_we) cmd_wdata <= bus.host_wdata;
            end else if (bg_gnt) begin
                cmd_addr <= bus.bg_addr;
            end else if (spr_gnt) begin
                cmd_addr <= bus.spr_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || frame_ended) begin
            starve_cnt <= '0;
        end else if (bus.host_valid && !host_gnt && (starve_cnt != 16'hFFFF)) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end

    vdp_vram_return_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_ret (
        .clk         (clk),
        .reset       (reset),
        .iss_vld     (iss_vld),
        .iss_owner   (iss_owner),
        .vram_rdata  (bus.vram_rdata),
        .rdata       (ret_rdata),
        .rdata_valid (ret_valid),
        .rdata_owner (ret_owner)
    );

    assign bus.bg_grant        = bg_gnt;
    assign bus.spr_grant       = spr_gnt;
    assign bus.host_ready      = host_gnt;
    assign bus.host_starve_cnt = starve_cnt;
    assign bus.vram_addr       = cmd_addr;
    assign bus.vram_we         = cmd_we;
    assign bus.vram_wdata      = cmd_wdata;
    assign bus.rdata           = ret_rdata;
    assign bus.rdata_valid     = ret_valid;
    assign bus.rdata_owner     = ret_owner;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a synchronous 1-cycle VRAM model.
module tb_vdp_vram_arbiter;
    import vdp_vram_arbiter_pkg::*;

    localparam int AW = 15;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset, hold_raster, active_display, frame_ended;
    int   tests = 0;
    int   fails = 0;
    int   nh, nb;

    vdp_vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vdp_vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_SLOT_INTERVAL(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .hold_raster    (hold_raster),
        .active_display (active_display),
        .frame_ended    (frame_ended),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as 16'h5A00 ^ addr.
    bit [DW-1:0] mem [0:(1<<AW)-1];
    bit          wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.vram_we) begin
            mem[bus.vram_addr] <= bus.vram_wdata;
            wr[bus.vram_addr]  <= 1'b1;
        end
        bus.vram_rdata <= wr[bus.vram_addr] ? mem[bus.vram_addr]
                                            : (16'h5A00 ^ {1'b0, bus.vram_addr});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hold_raster = 1'b0; active_display = 1'b0; frame_ended = 1'b0;
        bus.bg_req = 1'b1;  bus.bg_addr = '0;
        bus.spr_req = 1'b1; bus.spr_addr = '0;
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        tick; tick;
        settle;
        chk("rst_bg_grant",   bus.bg_grant, 0);
        chk("rst_spr_grant",  bus.spr_grant, 0);
        chk("rst_host_ready", bus.host_ready, 0);
        chk("rst_vram_addr",  bus.vram_addr, 0);
        chk("rst_vram_we",    bus.vram_we, 0);
        chk("rst_vram_wdata", bus.vram_wdata, 0);
        chk("rst_rvalid",     bus.rdata_valid, 0);
        chk("rst_rowner",     bus.rdata_owner, 0);
        chk("rst_rdata",      bus.rdata, 0);
        chk("rst_starve",     bus.host_starve_cnt, 0);

        // Blanking: host write wins over sprite and bg
        reset = 1'b0;
        bus.host_we = 1'b1; bus.host_addr = 15'h0123; bus.host_wdata = 16'hBEEF;
        bus.bg_addr = 15'h0040; bus.spr_addr = 15'h0050;
        settle;
        chk("blank_host_ready", bus.host_ready, 1);
        chk("blank_spr_grant",  bus.spr_grant, 0);
        chk("blank_bg_grant",   bus.bg_grant, 0);
        tick;
        bus.host_addr = 15'h7777; bus.host_wdata = 16'h1111; bus.host_valid = 1'b0;
        settle;
        chk("wr_vram_we",    bus.vram_we, 1);
        chk("wr_vram_addr",  bus.vram_addr, 15'h0123);
        chk("wr_vram_wdata", bus.vram_wdata, 16'hBEEF);
        chk("blank_spr_over_bg", bus.spr_grant, 1);
        chk("blank_bg_lose",     bus.bg_grant, 0);
        tick;
        bus.spr_req = 1'b0;
        settle;
        chk("spr_cmd_we",   bus.vram_we, 0);
        chk("spr_cmd_addr", bus.vram_addr, 15'h0050);
        chk("wr_no_rvalid", bus.rdata_valid, 0);
        chk("bg_grant_alone", bus.bg_grant, 1);
        tick;
        bus.bg_req = 1'b0;
        settle;
        chk("spr_rvalid", bus.rdata_valid, 1);
        chk("spr_rowner", bus.rdata_owner, 1);
        chk("spr_rdata",  bus.rdata, 16'h5A50);
        chk("bg_cmd_addr", bus.vram_addr, 15'h0040);
        tick;
        chk("bg_rvalid", bus.rdata_valid, 1);
        chk("bg_rowner", bus.rdata_owner, 0);
        chk("bg_rdata",  bus.rdata, 16'h5A40);
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 15'h0123;
        settle;
        chk("hrd_ready", bus.host_ready, 1);
        tick;
        bus.host_valid = 1'b0;
        settle;
        chk("hrd_gap_rvalid", bus.rdata_valid, 0);
        chk("hrd_cmd_addr",   bus.vram_addr, 15'h0123);
        tick;
        chk("hrd_rvalid", bus.rdata_valid, 1);
        chk("hrd_rowner", bus.rdata_owner, 2);
        chk("hrd_rdata",  bus.rdata, 16'hBEEF);

        // Active display, all requesting: host once per 8 cycles, bg otherwise
        tick;
        active_display = 1'b1;
        bus.bg_req = 1'b1; bus.spr_req = 1'b1; bus.host_valid = 1'b1;
        nh = 0; nb = 0;
        for (int i = 0; i < 16; i++) begin
            settle;
            chk("slot_host", bus.host_ready, (i % 8 == 7) ? 1 : 0);
            chk("slot_spr",  bus.spr_grant, 0);
            nh += int'(bus.host_ready);
            nb += int'(bus.bg_grant);
            tick;
        end
        chk("slot_host_total", nh, 2);
        chk("slot_bg_total",   nb, 14);
        bus.host_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle;
            chk("noslot_bg",   bus.bg_grant, 1);
            chk("noslot_host", bus.host_ready, 0);
            tick;
        end
        bus.host_valid = 1'b1;
        settle;
        chk("no_carry_host", bus.host_ready, 0);
        chk("no_carry_bg",   bus.bg_grant, 1);
        tick;

        // Frame end clears counters, then a 5-cycle raster hold
        frame_ended = 1'b1; bus.host_valid = 1'b0; bus.spr_req = 1'b0; bus.bg_addr = 15'h0041;
        settle;
        chk("fe_bg_grant", bus.bg_grant, 1);
        tick;
        frame_ended = 1'b0;
        settle;
        chk("fe_slot",   dut.slot_cnt, 0);
        chk("fe_starve", bus.host_starve_cnt, 0);
        chk("pre_hold_bg", bus.bg_grant, 1);
        tick;
        hold_raster = 1'b1; bus.host_valid = 1'b1;
        settle;
        chk("hold_bg",   bus.bg_grant, 0);
        chk("hold_spr",  bus.spr_grant, 0);
        chk("hold_host", bus.host_ready, 0);
        chk("hold_ret0_valid", bus.rdata_valid, 1);
        chk("hold_ret0_data",  bus.rdata, 16'h5A41);
        for (int i = 0; i < 4; i++) begin
            tick;
            settle;
            chk("hold_bg_n",   bus.bg_grant, 0);
            chk("hold_host_n", bus.host_ready, 0);
            chk("hold_we",     bus.vram_we, 0);
            if (i == 0) begin
                chk("hold_ret1_valid", bus.rdata_valid, 1);
                chk("hold_ret1_data",  bus.rdata, 16'h5A41);
            end else begin
                chk("hold_no_rvalid", bus.rdata_valid, 0);
            end
        end
        tick;
        chk("hold_starve", bus.host_starve_cnt, 5);
        chk("hold_slot",   dut.slot_cnt, 1);

        // Reset right after a sprite grant discards the in-flight read
        hold_raster = 1'b0; bus.host_valid = 1'b0; bus.bg_req = 1'b0;
        active_display = 1'b0; bus.spr_req = 1'b1;
        settle;
        chk("pre_rst_spr", bus.spr_grant, 1);
        tick;
        reset = 1'b1;
        settle;
        chk("in_rst_spr", bus.spr_grant, 0);
        tick;
        reset = 1'b0; bus.spr_req = 1'b0;
        settle;
        chk("mid_rst_vram_addr",  bus.vram_addr, 0);
        chk("mid_rst_vram_we",    bus.vram_we, 0);
        chk("mid_rst_vram_wdata", bus.vram_wdata, 0);
        chk("mid_rst_rvalid",     bus.rdata_valid, 0);
        chk("mid_rst_rowner",     bus.rdata_owner, 0);
        chk("mid_rst_rdata",      bus.rdata, 0);
        chk("mid_rst_starve",     bus.host_starve_cnt, 0);
        tick;
        chk("post_rst_rvalid1", bus.rdata_valid, 0);
        tick;
        chk("post_rst_rvalid2", bus.rdata_valid, 0);

        // Starve counter saturation, then frame-end clear
        active_display = 1'b1;
        tick; tick; tick;
        chk("sat_slot_pre", dut.slot_cnt, 3);
        hold_raster = 1'b1; bus.host_valid = 1'b1;
        for (int i = 0; i < 65534; i++) tick;
        chk("sat_fffe", bus.host_starve_cnt, 16'hFFFE);
        for (int i = 0; i < 6; i++) tick;
        chk("sat_ffff", bus.host_starve_cnt, 16'hFFFF);
        chk("sat_slot_frozen", dut.slot_cnt, 3);
        frame_ended = 1'b1;
        tick;
        frame_ended = 1'b0; hold_raster = 1'b0; bus.host_valid = 1'b0; active_display = 1'b0;
        chk("sat_fe_starve", bus.host_starve_cnt, 0);
        chk("sat_fe_slot",   dut.slot_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
